hub75_scan_ctrl: RTL and testbench

- Top-level HUB75 panel sequencer, directly upstream of the shift engine; it issues one shift request per (row, bit-plane).
- After each shift it blanks the panel, drives the row address and pulses LAT, then enables OE for a binary-weighted time (BCM).
- Presents the current fetch_row/fetch_plane to the fetch/shift path and signals frame completion.

---
 rtl/hub75_pkg.sv | 32 +++
 rtl/hub75_oe_timer.sv | 30 +++
 rtl/hub75_scan_ctrl.sv | 130 +++++++++++++
 tb/tb_hub75_scan_ctrl.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hub75_pkg.sv
// Shared HUB75 scan definitions: default geometry, state encoding and BCM weighting.
package hub75_pkg;

  localparam int unsigned DEF_ROW_BITS     = 5;
  localparam int unsigned DEF_PLANES       = 8;
  localparam int unsigned DEF_BASE_OE      = 16;
  localparam int unsigned DEF_BLANK_CYCLES = 2;

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_START      = 3'd1;
  localparam logic [2:0] ST_WAIT       = 3'd2;
  localparam logic [2:0] ST_BLANK_PRE  = 3'd3;
  localparam logic [2:0] ST_LATCH      = 3'd4;
  localparam logic [2:0] ST_BLANK_POST = 3'd5;
  localparam logic [2:0] ST_DISPLAY    = 3'd6;

  typedef enum logic [2:0] {
    IDLE       = ST_IDLE,
    START      = ST_START,
    WAIT       = ST_WAIT,
    BLANK_PRE  = ST_BLANK_PRE,
    LATCH      = ST_LATCH,
    BLANK_POST = ST_BLANK_POST,
    DISPLAY    = ST_DISPLAY
  } state_t;

  // Binary-weighted on-time of a bit-plane.
  function automatic int unsigned oe_cycles(input int unsigned base, input int unsigned plane);
    return base << plane;
  endfunction

endpackage

// File: rtl/hub75_oe_timer.sv
// Loadable down-counter; done is high once the loaded count has run out.
module hub75_oe_timer
  import hub75_pkg::*;
#(
  parameter int unsigned W = $clog2(DEF_BASE_OE) + DEF_PLANES
) (
  input  logic         sys_clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         done
);

  logic [W-1:0] count;

  // done is kept equal to (count == 0) but held in a flop.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      count <= '0;
      done  <= 1'b1;
    end else if (load) begin
      count <= value;
      done  <= (value == '0);
    end else if (count != '0) begin
      count <= count - W'(1);
      done  <= (count == W'(1));
    end
  end

endmodule

// File: rtl/hub75_scan_ctrl.sv
// HUB75 row/bit-plane sequencer: shift request, blank, latch, blank, BCM display.
module hub75_scan_ctrl
  import hub75_pkg::*;
#(
  parameter int unsigned ROW_BITS     = DEF_ROW_BITS,
  parameter int unsigned PLANES       = DEF_PLANES,
  parameter int unsigned BASE_OE      = DEF_BASE_OE,
  parameter int unsigned BLANK_CYCLES = DEF_BLANK_CYCLES,
  localparam int unsigned PL_W        = (PLANES > 1) ? $clog2(PLANES) : 1
) (
  input  logic                sys_clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                shift_busy,
  output logic                shift_start,
  output logic [ROW_BITS-1:0] fetch_row,
  output logic [PL_W-1:0]     fetch_plane,
  output logic [ROW_BITS-1:0] addr,
  output logic                lat,
  output logic                oe_n,
  output logic                frame_done
);

  localparam int unsigned         OE_W       = $clog2(BASE_OE) + PLANES;
  localparam logic [OE_W-1:0]     BLANK_LOAD = OE_W'(BLANK_CYCLES - 1);
  localparam logic [PL_W-1:0]     LAST_PLANE = PL_W'(PLANES - 1);
  localparam logic [ROW_BITS-1:0] LAST_ROW   = '1;

  state_t          state;
  logic            wait_first;
  logic            t_done;
  logic            t_load_c;
  logic [OE_W-1:0] t_value_c;

  // Timer reload points: entering each blank and entering DISPLAY.
  always_comb begin
    t_load_c  = 1'b0;
    t_value_c = BLANK_LOAD;
    unique case (state)
      WAIT:       t_load_c = !wait_first && !shift_busy;
      LATCH:      t_load_c = 1'b1;
      BLANK_POST: begin
        t_load_c  = t_done;
        t_value_c = OE_W'(oe_cycles(BASE_OE, 32'(fetch_plane)) - 1);
      end
      default: ;
    endcase
  end

  hub75_oe_timer #(.W(OE_W)) u_timer (
    .sys_clk (sys_clk),
    .rst     (rst),
    .load    (t_load_c),
    .value   (t_value_c),
    .done    (t_done)
  );

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state       <= IDLE;
      wait_first  <= 1'b0;
      shift_start <= 1'b0;
      lat         <= 1'b0;
      oe_n        <= 1'b1;
      addr        <= '0;
      fetch_row   <= '0;
      fetch_plane <= '0;
      frame_done  <= 1'b0;
    end else begin
      shift_start <= 1'b0;
      lat         <= 1'b0;
      frame_done  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (enable) begin
            state       <= START;
            shift_start <= 1'b1;
          end
        end
        START: begin
          state      <= WAIT;
          wait_first <= 1'b1;
        end
        // busy only rises the cycle after the start pulse, so skip one look.
        WAIT: begin
          wait_first <= 1'b0;
          if (!wait_first && !shift_busy) begin
            state <= BLANK_PRE;
            addr  <= fetch_row;
          end
        end
        BLANK_PRE: begin
          if (t_done) begin
            state <= LATCH;
            lat   <= 1'b1;
          end
        end
        LATCH: state <= BLANK_POST;
        BLANK_POST: begin
          if (t_done) begin
            state <= DISPLAY;
            oe_n  <= 1'b0;
          end
        end
        DISPLAY: begin
          if (t_done) begin
            oe_n       <= 1'b1;
            frame_done <= (fetch_row == LAST_ROW) && (fetch_plane == LAST_PLANE);
            if (enable) begin
              state       <= START;
              shift_start <= 1'b1;
              if (fetch_plane == LAST_PLANE) begin
                fetch_plane <= '0;
                fetch_row   <= fetch_row + ROW_BITS'(1);
              end else begin
                fetch_plane <= fetch_plane + PL_W'(1);
              end
            end else begin
              state       <= IDLE;
              fetch_row   <= '0;
              fetch_plane <= '0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hub75_scan_ctrl.sv
// Scoreboard bench: a default-size and a 4-row/2-plane sequencer against a slot-level model.
module tb_hub75_scan_ctrl;

  localparam int BASE  = 16;
  localparam int BLANK = 2;

  typedef struct {
    int row;
    int plane;
    int len;
    bit fd;
    int lat_cyc;
  } exp_t;

  logic sys_clk;
  logic rst;
  logic en [2];
  int   force_len [2];
  int   cyc;
  int   n_checks;
  int   n_fail;

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge sys_clk);
      cyc++;
    end
  end

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : u
    localparam int RB   = (g == 0) ? 5 : 2;
    localparam int PL   = (g == 0) ? 8 : 2;
    localparam int PLW  = $clog2(PL);
    localparam int ROWS = 1 << RB;

    logic           busy, shift_start, lat, oe_n, frame_done;
    logic [RB-1:0]  fetch_row, addr;
    logic [PLW-1:0] fetch_plane;

    hub75_scan_ctrl #(
      .ROW_BITS     (RB),
      .PLANES       (PL),
      .BASE_OE      (BASE),
      .BLANK_CYCLES (BLANK)
    ) dut (
      .sys_clk     (sys_clk),
      .rst         (rst),
      .enable      (en[g]),
      .shift_busy  (busy),
      .shift_start (shift_start),
      .fetch_row   (fetch_row),
      .fetch_plane (fetch_plane),
      .addr        (addr),
      .lat         (lat),
      .oe_n        (oe_n),
      .frame_done  (frame_done)
    );

    exp_t q [$];
    int   k;

    // Shift-engine model: busy high for L cycles starting one cycle after each
    // start; each start is one slot of the frame, so its expectation is queued here.
    int   busy_left, len_l;
    bit   last_disp_en;
    exp_t es;
    initial begin
      busy = 1'b0;
      k = 0;
      busy_left = 0;
      last_disp_en = 1'b1;
      forever begin
        @(negedge sys_clk);
        if (rst) begin
          k = 0;
          busy_left = 0;
          busy = 1'b0;
          last_disp_en = 1'b1;
        end else begin
          busy = (busy_left > 0);
          if (busy_left > 0) busy_left--;
          if (!oe_n) last_disp_en = en[g];
          if (shift_start) begin
            if (!last_disp_en) k = 0;
            last_disp_en = 1'b1;
            len_l = (force_len[g] != 0) ? force_len[g] : int'($urandom_range(1, 40));
            busy_left = len_l;
            es.plane   = k % PL;
            es.row     = (k / PL) % ROWS;
            es.len     = BASE << es.plane;
            es.fd      = (es.row == ROWS - 1) && (es.plane == PL - 1);
            // busy falls after len_l cycles of WAIT, then blank, then latch
            es.lat_cyc = cyc + (len_l + 1) + BLANK + 1;
            q.push_back(es);
            k++;
          end
        end
      end
    end

    // Monitor: reduces pin activity to slots and compares against the queue.
    int            since_rst, lat_c, disp_c, starts, first_en, nr, np;
    bit            in_rst, prev_oe, prev_lat, have_lat, m_last_en;
    logic [RB-1:0] lat_addr;
    exp_t          em;
    initial begin
      in_rst = 1'b0;
      since_rst = 0;
      forever begin
        @(negedge sys_clk);
        if (rst) begin
          if (in_rst) begin
            check($sformatf("u%0d_rst_oe_n", g), int'(oe_n), 1);
            check($sformatf("u%0d_rst_lat", g), int'(lat), 0);
            check($sformatf("u%0d_rst_start", g), int'(shift_start), 0);
            check($sformatf("u%0d_rst_fd", g), int'(frame_done), 0);
            check($sformatf("u%0d_rst_addr", g), int'(addr), 0);
            check($sformatf("u%0d_rst_row", g), int'(fetch_row), 0);
            check($sformatf("u%0d_rst_plane", g), int'(fetch_plane), 0);
          end
          in_rst = 1'b1;
          since_rst = 0;
          q.delete();
          have_lat = 1'b0;
          starts = 0;
          prev_oe = 1'b1;
          prev_lat = 1'b0;
          m_last_en = 1'b1;
        end else begin
          in_rst = 1'b0;
          since_rst++;
          if (since_rst == 1) begin
            check($sformatf("u%0d_idle_after_rst", g), int'(shift_start), 0);
            first_en = int'(en[g]);
          end
          if (since_rst == 2) check($sformatf("u%0d_start_after_rst", g), int'(shift_start), first_en);
          if (shift_start) starts++;
          if (prev_lat) check($sformatf("u%0d_lat_width", g), int'(lat), 0);
          if (lat && !prev_lat) begin
            check($sformatf("u%0d_lat_oe_overlap", g), int'(oe_n), 1);
            check($sformatf("u%0d_one_start", g), starts, 1);
            if (q.size() == 0) begin
              check($sformatf("u%0d_lat_unexpected", g), 1, 0);
            end else begin
              em = q[0];
              check($sformatf("u%0d_lat_time", g), cyc, em.lat_cyc);
              check($sformatf("u%0d_addr_at_lat", g), int'(addr), em.row);
              check($sformatf("u%0d_row_at_lat", g), int'(fetch_row), em.row);
              check($sformatf("u%0d_plane_at_lat", g), int'(fetch_plane), em.plane);
            end
            starts = 0;
            lat_c = cyc;
            lat_addr = addr;
            have_lat = 1'b1;
          end
          if (!oe_n && prev_oe) begin
            check($sformatf("u%0d_blank_post", g), have_lat ? cyc - lat_c : -1, BLANK + 1);
            disp_c = cyc;
          end
          if (!oe_n) m_last_en = en[g];
          if (oe_n && !prev_oe) begin
            if (q.size() == 0) begin
              check($sformatf("u%0d_display_unexpected", g), 1, 0);
            end else begin
              em = q.pop_front();
              check($sformatf("u%0d_oe_len_p%0d", g, em.plane), cyc - disp_c, em.len);
              check($sformatf("u%0d_addr_hold", g), int'(addr), int'(lat_addr));
              check($sformatf("u%0d_frame_done", g), int'(frame_done), int'(em.fd));
              if (!m_last_en) begin
                nr = 0;
                np = 0;
              end else begin
                np = (em.plane + 1) % PL;
                nr = (np == 0) ? (em.row + 1) % ROWS : em.row;
              end
              check($sformatf("u%0d_next_row", g), int'(fetch_row), nr);
              check($sformatf("u%0d_next_plane", g), int'(fetch_plane), np);
            end
            have_lat = 1'b0;
          end else if (frame_done) begin
            check($sformatf("u%0d_stray_frame_done", g), 1, 0);
          end
          prev_oe = oe_n;
          prev_lat = lat;
        end
      end
    end
  end

  int n;
  int bad;

  initial begin
    n_checks = 0;
    n_fail = 0;
    rst = 1'b1;
    en[0] = 1'b1;
    en[1] = 1'b1;
    force_len[0] = 0;
    force_len[1] = 0;
    repeat (3) @(posedge sys_clk);
    #1 rst = 1'b0;

    // Run instance 0 into the WAIT of row 1 / plane 3, then drop enable.
    n = 0;
    while (u[0].k < 12 && n < 20000) begin
      @(negedge sys_clk);
      n++;
    end
    check("u0_reach_row1_plane3", int'(u[0].k >= 12), 1);
    @(posedge sys_clk);
    #1 en[0] = 1'b0;
    repeat (400) @(negedge sys_clk);
    check("u0_idle_oe_n", int'(u[0].oe_n), 1);
    check("u0_idle_row", int'(u[0].fetch_row), 0);
    check("u0_idle_plane", int'(u[0].fetch_plane), 0);
    check("u0_idle_addr_held", int'(u[0].addr), 1);
    bad = 0;
    repeat (20) begin
      @(negedge sys_clk);
      if (u[0].shift_start) bad++;
    end
    check("u0_idle_no_start", bad, 0);

    // Restart, then reset in the middle of the first display.
    @(posedge sys_clk);
    #1 en[0] = 1'b1;
    n = 0;
    while (u[0].oe_n && n < 200) begin
      @(negedge sys_clk);
      n++;
    end
    check("u0_reach_display", int'(u[0].oe_n), 0);
    @(posedge sys_clk);
    #1 rst = 1'b1;
    @(posedge sys_clk);
    @(negedge sys_clk);
    check("u0_rst_mid_display_oe_n", int'(u[0].oe_n), 1);
    check("u0_rst_mid_display_lat", int'(u[0].lat), 0);
    force_len[0] = 500;
    @(posedge sys_clk);
    #1 rst = 1'b0;

    // A long shift must hold the block in WAIT with the panel dark.
    bad = 0;
    repeat (500) begin
      @(negedge sys_clk);
      if (!u[0].oe_n || u[0].lat) bad++;
    end
    check("u0_long_busy_dark", bad, 0);
    force_len[0] = 0;

    repeat (1500) @(posedge sys_clk);
    #1;
    en[0] = 1'b0;
    en[1] = 1'b0;
    repeat (2600) @(negedge sys_clk);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("u%0d_final_oe_n", i), int'((i == 0) ? u[0].oe_n : u[1].oe_n), 1);
      check($sformatf("u%0d_final_row", i), int'((i == 0) ? 5'(u[0].fetch_row) : 5'(u[1].fetch_row)), 0);
      check($sformatf("u%0d_final_plane", i), int'((i == 0) ? 3'(u[0].fetch_plane) : 3'(u[1].fetch_plane)), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
